// File: rtl/pps_gen_pkg.sv
// pps_gen_pkg: shared types and derived constants for the local PPS generator.
//   state_t        - generator state (DISABLED, FREERUN, LOCKED)
//   width_of()     - bit width needed to hold values 0..v-1
//   pulse_ticks()  - PPS high time in clk cycles
//   holdover_ticks()- watchdog reload value (1.1 s of clk cycles)
package pps_gen_pkg;

    typedef enum logic [1:0] {
        DISABLED = 2'd0,
        FREERUN  = 2'd1,
        LOCKED   = 2'd2
    } state_t;

    function automatic int unsigned width_of(input int unsigned v);
        return (v < 2) ? 1 : $clog2(v);
    endfunction

    function automatic int unsigned pulse_ticks(input int unsigned clk_rate,
                                                input int unsigned pulse_ms);
        return (clk_rate / 1000) * pulse_ms;
    endfunction

    function automatic int unsigned holdover_ticks(input int unsigned clk_rate);
        return clk_rate + clk_rate / 10;
    endfunction

endpackage

// File: rtl/pps_phase_cmp.sv
// pps_phase_cmp: combinational phase comparator.
// Converts the local phase seen in the strobe cycle into a signed error
// e = (phase+1) mod CLK_RATE folded into [-CLK_RATE/2, CLK_RATE/2).
//   phase  in   PH_W   current local phase counter value
//   err    out  ERR_W  signed phase error (positive: local second early)
//   in_tol out  1      |err| <= LOCK_TOL
module pps_phase_cmp
    import pps_gen_pkg::*;
#(
    parameter int unsigned CLK_RATE = 125000000,
    parameter int unsigned LOCK_TOL = 2,
    parameter int unsigned PH_W     = 27,
    parameter int unsigned ERR_W    = 28
) (
    input  logic [PH_W-1:0]         phase,
    output logic signed [ERR_W-1:0] err,
    output logic                    in_tol
);

    localparam logic [PH_W-1:0]         PHASE_LAST = PH_W'(CLK_RATE - 1);
    localparam logic [ERR_W-1:0]        RATE       = ERR_W'(CLK_RATE);
    localparam logic [ERR_W-1:0]        HALF       = ERR_W'(CLK_RATE / 2);
    localparam logic signed [ERR_W-1:0] TOL_P      = ERR_W'(LOCK_TOL);
    localparam logic signed [ERR_W-1:0] TOL_N      = -TOL_P;

    logic [ERR_W-1:0] next_phase;

    always_comb begin
        next_phase = (phase == PHASE_LAST) ? '0 : ERR_W'(phase) + ERR_W'(1);
        // Upper half of the second folds to negative (local second late).
        err    = (next_phase >= HALF) ? $signed(next_phase - RATE) : $signed(next_phase);
        in_tol = (err <= TOL_P) && (err >= TOL_N);
    end

endmodule

// File: rtl/pps_gen.sv
// pps_gen: local 1 Hz PPS generator, optionally disciplined to an external,
// already-qualified PPS strobe.
//   clk         in   system clock
//   rst         in   asynchronous active-high reset
//   enable      in   run enable
//   syncStrobe  in   one-cycle external PPS edge
//   syncValid   in   external PPS validity qualifier
//   pps         out  PPS output (high for PULSE_MS at the start of each second)
//   ppsStrobe   out  one-cycle pulse at the start of each local second
//   locked      out  phase locked to external PPS
//   phaseError  out  signed error latched on each qualified strobe
// Build option: PPS_GEN_PHASE_TRIM_EN - in LOCKED, a nonzero in-tolerance
// error also realigns the phase.
module pps_gen
    import pps_gen_pkg::*;
#(
    parameter int unsigned CLK_RATE   = 125000000,
    parameter int unsigned PULSE_MS   = 100,
    parameter int unsigned LOCK_TOL   = 2,
    parameter int unsigned LOCK_COUNT = 3
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic                       syncStrobe,
    input  logic                       syncValid,
    output logic                       pps,
    output logic                       ppsStrobe,
    output logic                       locked,
    output logic [$clog2(CLK_RATE):0]  phaseError
);

    localparam int unsigned PH_W           = width_of(CLK_RATE);
    localparam int unsigned ERR_W          = $clog2(CLK_RATE) + 1;
    localparam int unsigned PULSE_TICKS    = pulse_ticks(CLK_RATE, PULSE_MS);
    localparam int unsigned HOLDOVER_TICKS = holdover_ticks(CLK_RATE);
    localparam int unsigned WD_W           = width_of(HOLDOVER_TICKS + 1);
    localparam int unsigned GC_W           = width_of(LOCK_COUNT + 1);

    localparam logic [PH_W-1:0] PHASE_LAST = PH_W'(CLK_RATE - 1);
    localparam logic [PH_W-1:0] PULSE_LIM  = PH_W'(PULSE_TICKS);
    localparam logic [WD_W-1:0] WD_RELOAD  = WD_W'(HOLDOVER_TICKS);
    localparam logic [GC_W-1:0] GC_LOCK    = GC_W'(LOCK_COUNT);

    state_t                   state_q, state_n;
    logic [PH_W-1:0]          phase_q, phase_n, phase_inc;
    logic [GC_W-1:0]          good_q, good_n;
    logic [WD_W-1:0]          wd_q, wd_n;
    logic [ERR_W-1:0]         err_q, err_n;
    logic                     locked_n, pps_n, strobe_n;
    logic                     q, wd_expired;
    logic signed [ERR_W-1:0]  cmp_err;
    logic                     cmp_in_tol;

    pps_phase_cmp #(
        .CLK_RATE (CLK_RATE),
        .LOCK_TOL (LOCK_TOL),
        .PH_W     (PH_W),
        .ERR_W    (ERR_W)
    ) u_cmp (
        .phase  (phase_q),
        .err    (cmp_err),
        .in_tol (cmp_in_tol)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= DISABLED;
            phase_q   <= '0;
            good_q    <= '0;
            wd_q      <= WD_RELOAD;
            err_q     <= '0;
            locked    <= 1'b0;
            pps       <= 1'b0;
            ppsStrobe <= 1'b0;
        end else begin
            state_q   <= state_n;
            phase_q   <= phase_n;
            good_q    <= good_n;
            wd_q      <= wd_n;
            err_q     <= err_n;
            locked    <= locked_n;
            pps       <= pps_n;
            ppsStrobe <= strobe_n;
        end
    end

    assign phaseError = err_q;

    always_comb begin
        q          = syncStrobe && syncValid && enable && (state_q != DISABLED);
        phase_inc  = (phase_q == PHASE_LAST) ? '0 : phase_q + PH_W'(1);
        // Expires on the edge where the count would reach zero.
        wd_expired = (wd_q <= WD_W'(1));

        state_n  = state_q;
        phase_n  = phase_inc;
        good_n   = good_q;
        wd_n     = (wd_q != '0) ? wd_q - WD_W'(1) : '0;
        err_n    = err_q;
        locked_n = locked;

        if (q) begin
            wd_n  = WD_RELOAD;
            err_n = cmp_err;
        end

        if (!enable) begin
            state_n  = DISABLED;
            phase_n  = '0;
            good_n   = '0;
            locked_n = 1'b0;
        end else begin
            unique case (state_q)
                DISABLED: begin
                    // Hold phase at 0 for the first FREERUN cycle so the
                    // strobe fires as the state is entered.
                    state_n  = FREERUN;
                    phase_n  = '0;
                    good_n   = '0;
                    wd_n     = WD_RELOAD;
                    locked_n = 1'b0;
                end
                FREERUN: begin
                    if (q) begin
                        if (cmp_in_tol) begin
                            good_n = good_q + GC_W'(1);
                            if (good_q + GC_W'(1) >= GC_LOCK) begin
                                good_n   = GC_LOCK;
                                state_n  = LOCKED;
                                locked_n = 1'b1;
                            end
                        end else begin
                            phase_n = '0;
                            good_n  = '0;
                        end
                    end
                end
                LOCKED: begin
                    if (q) begin
                        if (cmp_in_tol) begin
`ifdef PPS_GEN_PHASE_TRIM_EN
                            if (cmp_err != '0) phase_n = '0;
`else
                            phase_n = phase_inc;
`endif
                        end else begin
                            phase_n  = '0;
                            good_n   = '0;
                            state_n  = FREERUN;
                            locked_n = 1'b0;
                        end
                    end else if (!syncValid || wd_expired) begin
                        // Holdover: phase keeps running undisturbed.
                        good_n   = '0;
                        state_n  = FREERUN;
                        locked_n = 1'b0;
                    end
                end
                default: begin
                    state_n  = DISABLED;
                    phase_n  = '0;
                    good_n   = '0;
                    locked_n = 1'b0;
                end
            endcase
        end

        // Outputs registered from next-phase so they line up with phase_q.
        pps_n    = (state_n != DISABLED) && (phase_n < PULSE_LIM);
        strobe_n = (state_n != DISABLED) && (phase_n == '0);
    end

endmodule

// File: doc/pps_gen.md
Name: pps_gen

Overview:
- Local 1 Hz PPS generator: the transmit-side counterpart of the PPS validity checker.
- Free-runs from a phase counter on `clk`.
- Optionally disciplines its phase to a qualified external PPS strobe (debounced, synchronized, validity-gated upstream).
- Drives the board PPS output and a one-cycle second strobe for the event/timestamp logic.

Parameters:
- CLK_RATE, 125000000: clk frequency in Hz; must be a multiple of 1000 and at least 2000.
- PULSE_MS, 100: PPS high time in ms, range 1..999. PULSE_TICKS = (CLK_RATE/1000)*PULSE_MS.
- LOCK_TOL, 2: maximum |phase error| in clk cycles treated as in-lock.
- LOCK_COUNT, 3: consecutive in-tolerance strobes required to declare lock.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- enable  in  1  generator run enable, synchronous to clk
- syncStrobe  in  1  single-cycle external PPS edge, already synchronous to clk
- syncValid  in  1  qualifier for syncStrobe (external PPS validity)
- pps  out  1  PPS output, registered
- ppsStrobe  out  1  one-cycle pulse marking the start of each local second
- locked  out  1  phase locked to external PPS
- phaseError  out  ERR_W  signed error latched at each qualified strobe; ERR_W = $clog2(CLK_RATE)+1

Behaviour:
- Reset (async, active-high) forces all of the following immediately, including mid-pulse or mid-lock:
  - phase=0, state=DISABLED, goodCnt=0, watchdog reloaded;
  - pps=0, ppsStrobe=0, locked=0, phaseError=0.
- Phase counter: 0..CLK_RATE-1, increments by 1 each cycle, wraps CLK_RATE-1 -> 0.
- pps and ppsStrobe are registered from next-phase, so in any cycle:
  - pps==1 iff phase<PULSE_TICKS;
  - ppsStrobe==1 iff phase==0.
- Qualified sync (Q): syncStrobe & syncValid & enable & state!=DISABLED.
- On Q, error e = (phase+1) mod CLK_RATE, mapped to the range [-CLK_RATE/2, CLK_RATE/2).
  - e=0 means the local second starts exactly one cycle after the strobe (fixed one-cycle latency).
  - Positive e means the local second started early.
  - phaseError <= e.
- "In tolerance" means |e|<=LOCK_TOL.
- Realign: force next phase=0, so ppsStrobe and the pps rise occur exactly one cycle after the strobe. The truncated or stretched second emits no extra strobe.
- States:
  - DISABLED: phase held at 0, outputs 0. When enable goes to 1, phase starts counting and the state moves to FREERUN. The first ppsStrobe occurs in the cycle the state enters FREERUN.
  - FREERUN:
    - Q in tolerance: goodCnt++. When goodCnt reaches LOCK_COUNT, move to LOCKED and set locked=1 in the same update.
    - Q out of tolerance: realign, goodCnt=0.
  - LOCKED:
    - Q in tolerance: no realign, unless the optional feature is enabled; watchdog reloaded.
    - Q out of tolerance: realign, goodCnt=0, move to FREERUN, locked=0.
    - Watchdog expiry, or syncValid==0: move to FREERUN (holdover), locked=0, goodCnt=0. Phase continues undisturbed.
- Watchdog: reloads to CLK_RATE+CLK_RATE/10 on every Q and decrements otherwise. Expiry is checked in LOCKED only.
- enable=0 from any state: next cycle state=DISABLED, pps=0, ppsStrobe=0, locked=0. phaseError is held.
- Simultaneous events:
  - enable falling with Q: enable wins.
  - Q in the cycle phase==CLK_RATE-1: e=0, in tolerance.
  - Realign when phase is already wrapping: identical to the natural wrap.
  - Watchdog expiry in the same cycle as Q: Q wins.

Optional Feature:
- Macro: PPS_GEN_PHASE_TRIM_EN.
- When defined: a nonzero in-tolerance error in LOCKED also realigns (phase forced to 0 one cycle after the strobe). State and locked are unchanged, so residual error is removed every second.
- When undefined: in-tolerance errors only update phaseError and the phase free-runs.

Decomposition:
- Package pps_gen_pkg:
  - state enum {DISABLED, FREERUN, LOCKED};
  - width function clog2-based for phase, ERR_W and watchdog;
  - PULSE_TICKS and HOLDOVER_TICKS derivation.
- Sub-module pps_phase_cmp: combinational. Takes phase and CLK_RATE, produces the signed e and the inTol flag.
- The top module holds the counter, watchdog, FSM and output registers.

Test Plan (CLK_RATE=2000, PULSE_MS=100 -> PULSE_TICKS=200, LOCK_TOL=2, LOCK_COUNT=3):
- Free run: release rst, enable=1, no sync -> ppsStrobe every 2000 cycles; pps high exactly 200 cycles per second; locked=0.
- Lock acquisition: Q one cycle before each local wrap, 3 times -> phaseError=0; locked=1 after the 3rd strobe; no phase jump.
- Realign: in FREERUN, Q at phase=49 -> phaseError=+50; ppsStrobe and pps rise the next cycle; next ppsStrobe 2000 cycles later.
- Tolerance edge, locked:
  - Q with e=+2 -> locked stays 1, no jump (trim off); with PPS_GEN_PHASE_TRIM_EN, jump and locked stays 1.
  - Q with e=+3 -> realign, locked=0.
- Holdover:
  - locked, then strobes stop -> locked=0 2200 cycles after the last Q; pps period stays 2000.
  - Separately, syncValid=0 -> locked=0 next cycle.
- Control mid-operation:
  - enable=0 at phase=100 -> pps=0 the next cycle; enable=1 -> ppsStrobe on restart.
  - rst asserted mid-pulse -> pps=0 with no clk edge required.
